axis_pkt_fifo: RTL and testbench

//  Synchronous AXI-Stream FIFO carrying tdata+tlast, with optional packet (store-and-forward) mode.

---
 rtl/axis_pkt_fifo.sv | 125 ++++++++++++
 tb/tb_axis_pkt_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_fifo.sv
// ---------------------------------------------------------------------------
// axis_pkt_fifo
//   Single-clock AXI-Stream FIFO carrying {tlast, tdata}. In stream mode a
//   word is offered downstream as soon as it is stored. In packet mode the
//   output waits until a whole packet (terminated by tlast) is buffered.
//   Exception: a completely full FIFO is always released, so a packet longer
//   than the FIFO cannot deadlock.
//   Also reports the fill level, the number of complete packets stored, and
//   almost-full / almost-empty flags.
//
// Ports
//   clk_i          rising-edge clock
//   arstn_i        asynchronous active-low reset
//   s_tdata        input data
//   s_tlast        input end-of-packet
//   s_tvalid       input valid
//   s_tready       input ready
//   m_tdata        output data, read combinationally at the read pointer
//   m_tlast        output end-of-packet
//   m_tvalid       output valid
//   m_tready       output ready
//   level_o        number of stored entries, 0..FIFO_DEPTH
//   pkt_cnt_o      number of stored entries that carry tlast
//   almost_full_o  level_o >= AFULL_THRESH
//   almost_empty_o level_o <= AEMPTY_THRESH
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
//   high. s_tready and m_tvalid are decoded from registered level and packet
//   count only, so they have no combinational path from m_tready or s_tvalid.
//   m_tvalid can drop only after a pop, so a presented beat stays valid and
//   stable until it is taken.
// ---------------------------------------------------------------------------
module axis_pkt_fifo #(
    parameter int DATA_WIDTH    = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int PACKET_MODE   = 0,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    localparam int LW           = $clog2(FIFO_DEPTH + 1),
    localparam int PW           = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [LW-1:0]         level_o,
    output logic [LW-1:0]         pkt_cnt_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o
);

    // Each entry is {tlast, tdata}.
    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [LW-1:0]       level;
    logic [LW-1:0]       pkt_cnt;
    logic                push;
    logic                pop;
    logic                push_last;
    logic                pop_last;
    logic                full;

    assign full     = (level == LW'(FIFO_DEPTH));
    assign s_tready = !full;

    // In packet mode the full escape hands an over-long packet downstream
    // cut-through, since its tlast can never be stored.
    assign m_tvalid = (PACKET_MODE != 0) ? ((pkt_cnt != '0) || full)
                                         : (level != '0);

    assign push      = s_tvalid && s_tready;
    assign pop       = m_tvalid && m_tready;
    assign push_last = push && s_tlast;
    assign pop_last  = pop && m_tlast;

    assign {m_tlast, m_tdata} = mem[rd_ptr];

    assign level_o        = level;
    assign pkt_cnt_o      = pkt_cnt;
    assign almost_full_o  = (32'(level) >= AFULL_THRESH);
    assign almost_empty_o = (32'(level) <= AEMPTY_THRESH);

    // Storage is deliberately left unreset. Its contents are ignored while
    // m_tvalid is low.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {s_tlast, s_tdata};
        end
    end

    // Pointers wrap by explicit compare, so any depth works (not just powers of two).
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            pkt_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            case ({push_last, pop_last})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_fifo
//   Instance 0: depth 4, stream mode.
//   Instance 1: depth 5, stream mode.
//   Instance 2: depth 4, packet mode.
//   The reference model holds the FIFO contents as a queue of {tlast, data}.
//   Level, packet count, ready, valid and the flags are all derived from that
//   queue.
// ---------------------------------------------------------------------------
module tb_axis_pkt_fifo;

    localparam int NI = 3;
    localparam int DEP [NI] = '{4, 5, 4};
    localparam int PM  [NI] = '{0, 0, 1};

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic [15:0] s_tdata   [NI];
    logic        s_tlast   [NI];
    logic        s_tvalid  [NI];
    logic        s_tready  [NI];
    logic [15:0] m_tdata   [NI];
    logic        m_tlast   [NI];
    logic        m_tvalid  [NI];
    logic        m_tready  [NI];
    logic [2:0]  level_o   [NI];
    logic [2:0]  pkt_cnt_o [NI];
    logic        almost_full_o  [NI];
    logic        almost_empty_o [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        axis_pkt_fifo #(
            .DATA_WIDTH (16),
            .FIFO_DEPTH (DEP[g]),
            .PACKET_MODE(PM[g])
        ) u_dut (
            .clk_i         (clk_i),
            .arstn_i       (arstn_i),
            .s_tdata       (s_tdata[g]),
            .s_tlast       (s_tlast[g]),
            .s_tvalid      (s_tvalid[g]),
            .s_tready      (s_tready[g]),
            .m_tdata       (m_tdata[g]),
            .m_tlast       (m_tlast[g]),
            .m_tvalid      (m_tvalid[g]),
            .m_tready      (m_tready[g]),
            .level_o       (level_o[g]),
            .pkt_cnt_o     (pkt_cnt_o[g]),
            .almost_full_o (almost_full_o[g]),
            .almost_empty_o(almost_empty_o[g])
        );
    end

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_q[$];
    logic        hold_valid = 1'b0;
    logic [16:0] hold_word;

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            s_tdata[i]  = '0;
            s_tlast[i]  = 1'b0;
            s_tvalid[i] = 1'b0;
            m_tready[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        arstn_i = 1'b0;
        idle_all();
        exp_q.delete();
        hold_valid = 1'b0;
        @(negedge clk_i);
        arstn_i = 1'b1;
    endtask

    // One clock of stimulus on instance k.
    //   Inputs are applied after the falling edge.
    //   Outputs are scored against the model, then the model steps at the rising edge.
    task automatic drive_cycle(input int k, input logic sv, input logic [15:0] sd,
                               input logic sl, input logic mr);
        int          lvl;
        int          pk;
        logic        exp_rdy;
        logic        exp_vld;
        logic [16:0] front;
        logic [7:0]  exp_st;
        logic [7:0]  got_st;
        s_tvalid[k] = sv;
        s_tdata[k]  = sd;
        s_tlast[k]  = sl;
        m_tready[k] = mr;
        #1;
        lvl = exp_q.size();
        pk  = 0;
        foreach (exp_q[i]) if (exp_q[i][16]) pk++;
        exp_rdy = (lvl != DEP[k]);
        exp_vld = (PM[k] != 0) ? ((pk != 0) || (lvl == DEP[k])) : (lvl != 0);
        exp_st  = {exp_rdy, exp_vld, (lvl >= DEP[k] - 1), (lvl <= 1), 4'(lvl)} ;
        exp_st[3:0] = {1'b0, 3'(lvl)};
        exp_st[7:4] = {exp_rdy, exp_vld, (lvl >= DEP[k] - 1), (lvl <= 1)};
        got_st  = {s_tready[k], m_tvalid[k], almost_full_o[k], almost_empty_o[k],
                   1'b0, level_o[k]};
        checks++;
        if (got_st !== exp_st) begin
            errors++;
            $display("FAIL status inst%0d: got rdy/vld/af/ae/lvl=%b expected %b", k, got_st, exp_st);
        end
        checks++;
        if (pkt_cnt_o[k] !== 3'(pk)) begin
            errors++;
            $display("FAIL pkt_cnt inst%0d: got %0d expected %0d", k, pkt_cnt_o[k], pk);
        end
        front = (lvl != 0) ? exp_q[0] : 17'h0;
        if (exp_vld) begin
            checks++;
            if ({m_tlast[k], m_tdata[k]} !== front) begin
                errors++;
                $display("FAIL data inst%0d: got %h expected %h", k, {m_tlast[k], m_tdata[k]}, front);
            end
        end
        if (hold_valid) begin
            checks++;
            if (m_tvalid[k] !== 1'b1 || {m_tlast[k], m_tdata[k]} !== hold_word) begin
                errors++;
                $display("FAIL stable inst%0d: got vld=%b %h expected vld=1 %h", k,
                         m_tvalid[k], {m_tlast[k], m_tdata[k]}, hold_word);
            end
        end
        hold_valid = exp_vld && !mr;
        hold_word  = {m_tlast[k], m_tdata[k]};
        @(posedge clk_i);
        if (mr && exp_vld) void'(exp_q.pop_front());
        if (sv && exp_rdy) exp_q.push_back({sl, sd});
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        arstn_i = 1'b0;
        idle_all();
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({s_tready[k], m_tvalid[k], almost_full_o[k], almost_empty_o[k], level_o[k], pkt_cnt_o[k]}
                !== {4'b1001, 3'd0, 3'd0}) begin
                errors++;
                $display("FAIL reset inst%0d: got rdy=%b vld=%b af=%b ae=%b lvl=%0d pk=%0d", k,
                         s_tready[k], m_tvalid[k], almost_full_o[k], almost_empty_o[k],
                         level_o[k], pkt_cnt_o[k]);
            end
        end
        @(negedge clk_i);
        arstn_i = 1'b1;
    endtask

    task automatic test_fill_drain();
        logic [15:0] v;
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(0, 1'b1, 16'(17 * (i + 1)), 1'b0, 1'b0);
        checks++;
        if (s_tready[0] !== 1'b0 || level_o[0] !== 3'd4 || almost_full_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL fill: got rdy=%b lvl=%0d af=%b expected 0 4 1", s_tready[0], level_o[0], almost_full_o[0]);
        end
        for (int i = 0; i < 4; i++) begin
            v = 16'(17 * (i + 1));
            checks++;
            if (m_tdata[0] !== v) begin
                errors++;
                $display("FAIL drain_order: got %h expected %h", m_tdata[0], v);
            end
            drive_cycle(0, 1'b0, 16'h0, 1'b0, 1'b1);
        end
        checks++;
        if (level_o[0] !== 3'd0 || m_tvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL drained: got lvl=%0d vld=%b expected 0 0", level_o[0], m_tvalid[0]);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(0, 1'b1, 16'($urandom), 1'b0, 1'b0);
        drive_cycle(0, 1'b1, 16'hBEEF, 1'b0, 1'b1);
        checks++;
        if (s_tready[0] !== 1'b1 || level_o[0] !== 3'd3) begin
            errors++;
            $display("FAIL full_pop: got rdy=%b lvl=%0d expected 1 3", s_tready[0], level_o[0]);
        end
    endtask

    task automatic test_back_to_back(input int k);
        do_reset();
        for (int i = 0; i < 2; i++) drive_cycle(k, 1'b1, 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(k, 1'b1, 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if (level_o[k] !== 3'd2 || s_tready[k] !== 1'b1) begin
                errors++;
                $display("FAIL b2b inst%0d cyc%0d: got lvl=%0d rdy=%b expected 2 1", k, i, level_o[k], s_tready[k]);
            end
        end
    endtask

    task automatic test_packet();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(2, 1'b1, 16'h0A0 + 16'(i), (i == 2), 1'b0);
            checks++;
            if (m_tvalid[2] !== (i == 2)) begin
                errors++;
                $display("FAIL pkt_hold word%0d: got vld=%b expected %b", i, m_tvalid[2], (i == 2));
            end
        end
        checks++;
        if (pkt_cnt_o[2] !== 3'd1) begin
            errors++;
            $display("FAIL pkt_count: got %0d expected 1", pkt_cnt_o[2]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_tlast[2] !== (i == 2)) begin
                errors++;
                $display("FAIL pkt_tlast word%0d: got %b expected %b", i, m_tlast[2], (i == 2));
            end
            drive_cycle(2, 1'b0, 16'h0, 1'b0, 1'b1);
        end
        checks++;
        if (pkt_cnt_o[2] !== 3'd0 || m_tvalid[2] !== 1'b0) begin
            errors++;
            $display("FAIL pkt_empty: got pk=%0d vld=%b expected 0 0", pkt_cnt_o[2], m_tvalid[2]);
        end
    endtask

    task automatic test_escape();
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(2, 1'b1, 16'($urandom), 1'b0, 1'b0);
        checks++;
        if (m_tvalid[2] !== 1'b1 || level_o[2] !== 3'd4) begin
            errors++;
            $display("FAIL escape: got vld=%b lvl=%0d expected 1 4", m_tvalid[2], level_o[2]);
        end
        drive_cycle(2, 1'b0, 16'h0, 1'b0, 1'b1);
        drive_cycle(2, 1'b1, 16'h7777, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(2, 1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(2, 1'b1, 16'($urandom), (i == 0), 1'b0);
        #2;
        arstn_i = 1'b0;
        #1;
        checks++;
        if ({m_tvalid[2], s_tready[2], level_o[2], pkt_cnt_o[2]} !== {2'b01, 3'd0, 3'd0}) begin
            errors++;
            $display("FAIL reset_mid: got vld=%b rdy=%b lvl=%0d pk=%0d expected 0 1 0 0",
                     m_tvalid[2], s_tready[2], level_o[2], pkt_cnt_o[2]);
        end
        exp_q.delete();
        hold_valid = 1'b0;
        @(negedge clk_i);
        arstn_i = 1'b1;
        drive_cycle(2, 1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic test_random(input int k);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(k, 1'($urandom_range(0, 3) != 0), 16'($urandom),
                        ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_pop();
        test_back_to_back(0);
        test_back_to_back(1);
        test_packet();
        test_escape();
        test_reset_mid();
        for (int k = 0; k < NI; k++) test_random(k);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
